// File: rtl/des_sbox_scheduler_if.sv
// Handshake and S-box port bundle for des_sbox_scheduler. The slave side is the scheduler.
// DES bit numbering is MSB-first, so the data fields use ascending ranges.
interface des_sbox_scheduler_if #(
    parameter int SEL_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [1:48]      in_data;
    logic [SEL_W-1:0] sbox_sel;
    logic [1:6]       sbox_in;
    logic [1:4]       sbox_out;
    logic             out_valid;
    logic             out_ready;
    logic [1:32]      out_data;
    logic             busy;

    modport slave (
        input  in_valid, in_data, sbox_out, out_ready,
        output in_ready, sbox_sel, sbox_in, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, sbox_out, out_ready,
        input  in_ready, sbox_sel, sbox_in, out_valid, out_data, busy
    );
endinterface

// File: rtl/des_sbox_scheduler.sv
// Time-shares one S-box lookup port across S1..S8 for a single DES round function.
// Define SBOX_SCHED_REG_LOOKUP_EN when the S-box port has one cycle of read latency.
module des_sbox_scheduler #(
    parameter int NUM_SBOX = 8,
    parameter int SEL_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    des_sbox_scheduler_if.slave bus
);

`ifdef SBOX_SCHED_REG_LOOKUP_EN
    // One extra cycle drains the registered port; the counter needs one more bit.
    localparam int               CNT_W = SEL_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_SBOX);
`else
    localparam int               CNT_W = SEL_W;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_SBOX - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:48]      data_q, data_d;
    logic [3:0]       nib_q [NUM_SBOX];
    logic [3:0]       nib_d [NUM_SBOX];

    logic [1:6]       chunk [NUM_SBOX];
    logic [1:32]      out_w;
    logic [SEL_W-1:0] addr_idx;
    logic [SEL_W-1:0] cap_idx;
    logic             addr_vld;
    logic             cap_vld;
    logic             in_rdy;

    always_comb begin
        chunk = '{default: '0};
        out_w = '0;
        for (int k = 0; k < NUM_SBOX; k++) begin
            chunk[k]          = data_q[6*k+1 +: 6];
            out_w[4*k+1 +: 4] = nib_q[k];
        end
    end

    assign addr_idx = cnt_q[SEL_W-1:0];

`ifdef SBOX_SCHED_REG_LOOKUP_EN
    // Cycle i drives address i and captures the data returned for address i-1.
    assign addr_vld = !cnt_q[SEL_W];
    assign cap_vld  = (cnt_q != '0);
    assign cap_idx  = SEL_W'(cnt_q - 1'b1);
`else
    assign addr_vld = 1'b1;
    assign cap_vld  = 1'b1;
    assign cap_idx  = cnt_q;
`endif

    assign in_rdy = (state_q == IDLE) && !rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        nib_d   = nib_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_rdy) begin
                    data_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cap_vld) nib_d[cap_idx] = bus.sbox_out;
                if (cnt_q == LAST) state_d = DONE;
                else               cnt_d   = cnt_q + 1'b1;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            for (int k = 0; k < NUM_SBOX; k++) nib_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            nib_q   <= nib_d;
        end
    end

    // Address lines are parked at zero whenever no lookup is being issued.
    assign bus.sbox_sel  = (state_q == LOOKUP && addr_vld) ? addr_idx : '0;
    assign bus.sbox_in   = (state_q == LOOKUP && addr_vld) ? chunk[addr_idx] : '0;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_w;
    assign bus.busy      = (state_q != IDLE);

    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_data));

    a_ready_idle: assert property (@(posedge clk) disable iff (rst)
        !(bus.in_ready && bus.busy));

endmodule

// File: tb/tb_des_sbox_scheduler.sv
// Directed bench for des_sbox_scheduler: table of words plus stall, in_valid-pulse and reset sequences.
module tb_des_sbox_scheduler;
    localparam int SEL_W = 3;
`ifdef SBOX_SCHED_REG_LOOKUP_EN
    localparam int LOOK = 9;
`else
    localparam int LOOK = 8;
`endif
    // S5 table, index = row*16 + col, row = {b1,b6}, col = b2..b5
    localparam int S5 [64] = '{
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3};

    typedef struct {
        int          mode;
        logic [47:0] din;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   mode;
    int   n_chk  = 0;
    int   n_pass = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    des_sbox_scheduler_if #(.SEL_W(SEL_W)) bus ();

    des_sbox_scheduler #(.NUM_SBOX(8), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // mode 0: every slot returns sel+1; mode 1: slot 4 is S5, others return 0
    function automatic logic [3:0] lut(input int m, input logic [2:0] s, input logic [5:0] a);
        int r, c;
        if (m == 0) return {1'b0, s} + 4'd1;
        if (s != 3'd4) return 4'd0;
        r = int'({a[5], a[0]});
        c = int'(a[4:1]);
        return 4'(S5[r*16 + c]);
    endfunction

    logic [3:0] comb_out;
    always_comb comb_out = lut(mode, bus.sbox_sel, bus.sbox_in);
`ifdef SBOX_SCHED_REG_LOOKUP_EN
    logic [3:0] reg_out;
    always_ff @(posedge clk) reg_out <= comb_out;
    assign bus.sbox_out = reg_out;
`else
    assign bus.sbox_out = comb_out;
`endif

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Offers one word and follows it cycle by cycle; pulse_at/rst_at are lookup-cycle indices or -1.
    task automatic run_word(input int m, input logic [47:0] din, input logic [31:0] exp,
                            input int stall, input int pulse_at, input int rst_at);
        int          w;
        int          seen;
        logic [5:0]  ec;
        logic [2:0]  es;
        mode = m;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_word", 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = din;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = ~din;
        for (int j = 0; j < LOOK; j++) begin
            check("lookup_flags", 64'({bus.busy, bus.out_valid, bus.in_ready}), 64'(3'b100));
            if (j < 8) begin
                es = 3'(j);
                ec = din[47-6*j -: 6];
            end else begin
                es = '0;
                ec = '0;
            end
            check("sbox_sel", 64'(bus.sbox_sel), 64'(es));
            check("sbox_in", 64'(bus.sbox_in), 64'(ec));
            bus.in_valid = (j == pulse_at);
            if (j == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check("post_rst_flags", 64'({bus.busy, bus.out_valid, bus.in_ready}), 64'(3'b001));
                check("post_rst_out_data", 64'(bus.out_data), 64'(0));
                seen = 0;
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    if (bus.out_valid || bus.busy) seen++;
                end
                check("post_rst_no_result", 64'(seen), 64'(0));
                return;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("done_out_valid", 64'(bus.out_valid), 64'(1));
        check("done_out_data", 64'(bus.out_data), 64'(exp));
        check("done_in_ready", 64'(bus.in_ready), 64'(0));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_hold", 64'({bus.out_valid, bus.in_ready, bus.out_data}),
                  64'({1'b1, 1'b0, exp}));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("release_flags", 64'({bus.busy, bus.out_valid, bus.in_ready}), 64'(3'b001));
        check("release_out_data_kept", 64'(bus.out_data), 64'(exp));
    endtask

    initial begin
        int seen;
        vecs[0] = '{0, 48'h000000000000, 32'h12345678};
        vecs[1] = '{0, 48'hFFFFFFFFFFFF, 32'h12345678};
        vecs[2] = '{1, 48'h000000000000, 32'h00002000};
        vecs[3] = '{1, 48'h000000FC0000, 32'h00003000};
        vecs[4] = '{1, 48'h000000040000, 32'h0000E000};
        vecs[5] = '{1, 48'h000000800000, 32'h00004000};
        vecs[6] = '{1, 48'hFFFFFF7BFFFF, 32'h00009000};
        vecs[7] = '{1, 48'hFFFFFFFFFFFF, 32'h00003000};

        rst           = 1'b1;
        mode          = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_flags", 64'({bus.busy, bus.out_valid}), 64'(0));
        check("rst_sbox", 64'({bus.sbox_sel, bus.sbox_in}), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_out_ready_noop", 64'({bus.busy, bus.out_valid, bus.in_ready}), 64'(3'b001));

        for (int i = 0; i < 8; i++)
            run_word(vecs[i].mode, vecs[i].din, vecs[i].exp, 0, -1, -1);

        run_word(0, 48'hFFFFFFFFFFFF, 32'h12345678, 20, -1, -1);

        run_word(0, 48'h0123456789AB, 32'h12345678, 0, 2, -1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.busy || bus.out_valid) seen++;
        end
        check("single_result_only", 64'(seen), 64'(0));

        run_word(1, 48'h000000FC0000, 32'h00003000, 0, -1, 4);
        run_word(1, 48'h000000040000, 32'h0000E000, 0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
